// File: rtl/meteor_pkg.sv
// meteor_pkg: shared types and constants for the meteor field.
//   slot_state_e : per-slot IDLE/ACTIVE state
//   slot_t       : packed per-slot payload (state, x, y, size)
//   spawn_slot() : builds a freshly spawned slot from an LFSR word
package meteor_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } slot_state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam int unsigned SIZE_MIN  = 16;
  localparam int unsigned Y_MIN     = 32;
  localparam int unsigned H_RES     = 640;
  localparam int unsigned V_RES     = 480;

  localparam int unsigned XW   = 10;  // coordinate width
  localparam int unsigned SZW  = 6;   // sprite size width
  localparam int unsigned CNTW = 8;   // spawn counter / passed counter width
  localparam int unsigned SPW  = 4;   // per-slot speed width

  typedef struct packed {
    slot_state_e    state;
    logic [XW-1:0]  x;
    logic [XW-1:0]  y;
    logic [SZW-1:0] size;
  } slot_t;

  localparam slot_t SLOT_RESET = '{state: IDLE, x: '0, y: '0, size: '0};

  // New meteor: y from the upper LFSR byte, size from the low five bits.
  function automatic slot_t spawn_slot(input logic [15:0] rnd, input logic [XW-1:0] x0);
    slot_t s;
    s.state = ACTIVE;
    s.x     = x0;
    s.y     = XW'(rnd[15:8]) + XW'(Y_MIN);
    s.size  = SZW'(SIZE_MIN) + SZW'(rnd[4:0]);
    return s;
  endfunction

endpackage

// File: rtl/meteor_field_if.sv
// meteor_field_if: pixel/frame bus between the video pipeline and the meteor field.
//   frame_tick, pix_x, pix_y, player_on, hit_clr : driven by master
//   meteor_on, hit, passed_cnt, active_mask       : driven by slave (meteor_field)
interface meteor_field_if #(
  parameter int unsigned N_SLOTS = 4
) ();

  logic               frame_tick;
  logic [9:0]         pix_x;
  logic [9:0]         pix_y;
  logic               player_on;
  logic               hit_clr;
  logic               meteor_on;
  logic               hit;
  logic [7:0]         passed_cnt;
  logic [N_SLOTS-1:0] active_mask;

  modport master (
    output frame_tick, pix_x, pix_y, player_on, hit_clr,
    input  meteor_on, hit, passed_cnt, active_mask
  );

  modport slave (
    input  frame_tick, pix_x, pix_y, player_on, hit_clr,
    output meteor_on, hit, passed_cnt, active_mask
  );

endinterface

// File: rtl/meteor_lfsr16.sv
// meteor_lfsr16: free-running 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1.
//   clk, rst_n : clock, async active-low reset (loads LFSR_SEED)
//   q          : current LFSR value, advances every clk cycle
module meteor_lfsr16
  import meteor_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic [15:0] q_d;

  // Right-shifting form: taps 16,14,13,11 map to bits 0,2,3,5.
  always_comb begin
    q_d = {q_q[0] ^ q_q[2] ^ q_q[3] ^ q_q[5], q_q[15:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= LFSR_SEED;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/meteor_field.sv
// meteor_field: array of N_SLOTS meteors drifting left, with spawning,
// expiry counting and a sticky player-collision flag.
//   clk, rst_n : clock, async active-low reset
//   bus        : meteor_field_if slave (frame_tick, pix_x/y, player_on, hit_clr
//                in; meteor_on (combinational), hit, passed_cnt, active_mask out)
// Optional build macro METEOR_VARSPEED_EN: per-slot speed 1 + (LFSR[3:0] mod SPEED)
// latched at spawn; otherwise every slot moves by SPEED.
module meteor_field
  import meteor_pkg::*;
#(
  parameter int unsigned N_SLOTS      = 4,
  parameter int unsigned SPEED        = 2,
  parameter int unsigned SPAWN_FRAMES = 60,
  parameter int unsigned START_X      = 640
) (
  input logic           clk,
  input logic           rst_n,
  meteor_field_if.slave bus
);

  localparam int unsigned ECW = 4;  // expiries per tick, up to 8 slots

  logic [15:0]        lfsr;
  logic [N_SLOTS-1:0] active;
  logic [N_SLOTS-1:0] expire;
  logic [N_SLOTS-1:0] overlap;
  logic [N_SLOTS-1:0] spawn_sel;
  logic               spawn_now;
  logic               found;
  logic               meteor_on_c;

  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [CNTW-1:0]    passed_q, passed_d;
  logic [ECW-1:0]     n_exp;
  logic [CNTW:0]      passed_sum;
  logic               hit_q, hit_d;

  meteor_lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (lfsr)
  );

  assign spawn_now = bus.frame_tick && (cnt_q == CNTW'(SPAWN_FRAMES - 1));

  // Spawn counter: wraps on the attempt tick whether or not a slot is free.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.frame_tick) cnt_d = spawn_now ? '0 : cnt_q + CNTW'(1);
  end

  // Lowest IDLE slot in the pre-tick state, so a slot expiring now is not reused.
  always_comb begin
    spawn_sel = '0;
    found     = 1'b0;
    for (int i = 0; i < int'(N_SLOTS); i++) begin
      if (!found && !active[i]) begin
        spawn_sel[i] = spawn_now;
        found        = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < N_SLOTS; g++) begin : g_slot
    slot_t          slot_q, slot_d;
    logic [SPW-1:0] spd;

`ifdef METEOR_VARSPEED_EN
    logic [SPW-1:0] spd_q, spd_d;
    assign spd = spd_q;
`else
    assign spd = SPW'(SPEED);
`endif

    assign active[g]  = (slot_q.state == ACTIVE);
    assign expire[g]  = bus.frame_tick && active[g] && (slot_q.x < XW'(spd));
    // Bounds compared at 11 bits so x+size never wraps.
    assign overlap[g] = active[g]
                     && ({1'b0, slot_q.x} <= {1'b0, bus.pix_x})
                     && ({1'b0, bus.pix_x} < ({1'b0, slot_q.x} + 11'(slot_q.size)))
                     && ({1'b0, slot_q.y} <= {1'b0, bus.pix_y})
                     && ({1'b0, bus.pix_y} < ({1'b0, slot_q.y} + 11'(slot_q.size)));

    // Per-slot step / expire / spawn on a frame tick.
    always_comb begin
      slot_d = slot_q;
`ifdef METEOR_VARSPEED_EN
      spd_d  = spd_q;
`endif
      if (bus.frame_tick) begin
        if (expire[g]) begin
          slot_d.state = IDLE;
          slot_d.x     = '0;
        end else if (active[g]) begin
          slot_d.x = slot_q.x - XW'(spd);
        end else if (spawn_sel[g]) begin
          slot_d = spawn_slot(lfsr, XW'(START_X));
`ifdef METEOR_VARSPEED_EN
          spd_d  = SPW'(1) + SPW'(lfsr[3:0] % SPW'(SPEED));
`endif
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        slot_q <= SLOT_RESET;
`ifdef METEOR_VARSPEED_EN
        spd_q  <= '0;
`endif
      end else begin
        slot_q <= slot_d;
`ifdef METEOR_VARSPEED_EN
        spd_q  <= spd_d;
`endif
      end
    end
  end

  // Saturating count of meteors leaving the screen, several per tick allowed.
  always_comb begin
    n_exp = '0;
    for (int i = 0; i < int'(N_SLOTS); i++) n_exp = n_exp + ECW'(expire[i]);
    passed_sum = (CNTW+1)'(passed_q) + (CNTW+1)'(n_exp);
    passed_d   = passed_sum[CNTW] ? {CNTW{1'b1}} : passed_sum[CNTW-1:0];
  end

  assign meteor_on_c = |overlap;

  // Sticky hit: a set in the same cycle as a clear wins.
  always_comb begin
    hit_d = (meteor_on_c && bus.player_on) || (hit_q && !bus.hit_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      passed_q <= '0;
      hit_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      passed_q <= passed_d;
      hit_q    <= hit_d;
    end
  end

  assign bus.meteor_on   = meteor_on_c;
  assign bus.hit         = hit_q;
  assign bus.passed_cnt  = passed_q;
  assign bus.active_mask = active;

endmodule
